bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with run/stop control: load a preset such as 25, start it, and it counts down one step per enabled tick until it reaches 00.
- Counterpart of the team's free-running 0-9 up-counter: decrementing rather than incrementing, with a preset load and a terminal-count event.
- Sits between a tick prescaler (e.g. 1 Hz enable) and the seven-segment display path.
- All sequential logic runs on one clock.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..4); q width = 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  count enable, one-cycle pulse from the prescaler.
- load  in  1  preset strobe.
- load_val  in  4*NUM_DIGITS  preset value, BCD, digit 0 in bits [3:0].
- start  in  1  start/resume strobe.
- stop  in  1  pause strobe.
- q  out  4*NUM_DIGITS  current count, BCD.
- running  out  1  high while in RUN.
- expired  out  1  level, high while in DONE.
- done_pulse  out  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset: one clock, clk; asynchronous, active-low reset reset_n.
- While reset_n=0:
  - q=0 and preset register=0.
  - State IDLE.
  - running=0, expired=0, done_pulse=0.
- Release of reset_n is synchronous to the next clk edge.
- All outputs are registered.
- FSM states:
  - IDLE: stopped or paused, q held.
  - RUN: counting.
  - DONE: q=0, holding.
- Per-cycle priority: load > stop > start > tick.
- load, in any state:
  - q <= sanitised load_val; preset register <= the same value.
  - Next state IDLE; expired cleared. done_pulse=0 that cycle.
  - Sanitising: any digit >9 is clamped to 9 (e.g. 0x3C -> 0x39).
- IDLE:
  - start with q!=0 -> RUN; q unchanged in that cycle.
  - start with q==0 -> ignored, stays IDLE.
  - tick is ignored.
- RUN:
  - stop -> IDLE, q held; no decrement, even with tick in the same cycle.
  - tick -> BCD decrement:
    - Digit 0 decrements.
    - A digit at 0 becomes 9 and borrows from the next digit (e.g. 40 -> 39, 100 -> 099).
  - If the decrement yields q==0: next state DONE, and done_pulse=1 for exactly the cycle in which q first reads 0.
  - start while in RUN: no effect.
- DONE:
  - expired=1, running=0, q=0.
  - start reloads q from the preset register and goes to RUN.
  - If the preset is 0, start is ignored.
  - stop and tick are ignored.
- No underflow: q never decrements below 0.
- Decrement latency: q updates on the clk edge at which tick is sampled high.
- running mirrors (state==RUN) in the same cycle.

Decomposition:
- Shared package:
  - State encoding, 2-bit: IDLE=0, RUN=1, DONE=2.
  - BCD_MAX = 4'd9.
  - BCD digit width = 4.
- Sub-module bcd_digit_down, one digit, combinational:
  - Inputs: digit, borrow_in.
  - Outputs: next_digit, borrow_out.
- Top level instantiates NUM_DIGITS copies in a generate chain; borrow_in of digit 0 = decrement enable.

Test Plan:
- Reset: hold reset_n=0 mid-count at q=17 -> q=00, running=0, expired=0 asynchronously, before the next clk edge.
- Full countdown:
  - load 0x12, start, then 12 ticks -> q=11,10,09,...,01,00.
  - done_pulse high exactly one cycle when q=00; expired=1 afterwards; further ticks leave q=00.
- Pause and collision:
  - In RUN at 0x25, assert stop and tick in the same cycle -> q stays 25, state IDLE.
  - start then tick -> q=24.
- Borrow and clamp:
  - NUM_DIGITS=3, load 0x100, start, tick -> q=099.
  - load 0x3C -> q=039.
- Restart from DONE:
  - After expiring from preset 05, start -> q=05, running=1.
  - Start with preset 00 -> stays DONE.
- Load priority: in RUN, load 0x30 together with stop, start and tick in the same cycle -> q=30, IDLE, expired=0, no decrement.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, BCD digit
// constants and the digit clamp used when sanitising preset values.
package bcd_countdown_timer_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Any nibble above 9 is not a BCD digit; pin it to the largest legal one.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        logic [3:0] result;
        if (digit > BCD_MAX) begin
            result = BCD_MAX;
        end else begin
            result = digit;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD digit of the down-counter: subtracts the incoming borrow and
// produces the borrow for the next more-significant digit.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    // Digit decrement with wrap 0 -> 9 and borrow propagation.
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_MIN) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            next_digit = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with preset load, run/pause control and a
// terminal-count event; all outputs come straight from registers.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tick,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     load_val,
    input  logic                        start,
    input  logic                        stop,
    output logic [4*NUM_DIGITS-1:0]     q,
    output logic                        running,
    output logic                        expired,
    output logic                        done_pulse
);

    localparam int QW = BCD_W * NUM_DIGITS;

    state_t          r_state;
    logic [QW-1:0]   r_q;
    logic [QW-1:0]   r_preset;
    logic            r_running;
    logic            r_expired;
    logic            r_done_pulse;

    logic [QW-1:0]   w_load_clean;
    logic [QW-1:0]   w_q_dec;
    logic [NUM_DIGITS:0] w_borrow;
    logic            w_dec_en;
    logic            w_dec_ok;
    logic            w_q_zero;
    logic            w_dec_zero;
    logic            w_preset_zero;

    assign w_dec_en      = (r_state == ST_RUN) & tick;
    assign w_borrow[0]   = w_dec_en;
    // A borrow out of the top digit would mean underflow; refuse that step.
    assign w_dec_ok      = ~w_borrow[NUM_DIGITS];
    assign w_q_zero      = (r_q == {QW{1'b0}});
    assign w_dec_zero    = (w_q_dec == {QW{1'b0}});
    assign w_preset_zero = (r_preset == {QW{1'b0}});

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            assign w_load_clean[g*BCD_W +: BCD_W] = bcd_clamp(load_val[g*BCD_W +: BCD_W]);

            bcd_digit_down u_digit (
                .digit      (r_q[g*BCD_W +: BCD_W]),
                .borrow_in  (w_borrow[g]),
                .next_digit (w_q_dec[g*BCD_W +: BCD_W]),
                .borrow_out (w_borrow[g+1])
            );
        end
    endgenerate

    // Control FSM; status outputs are updated alongside the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_q          <= {QW{1'b0}};
            r_preset     <= {QW{1'b0}};
            r_running    <= 1'b0;
            r_expired    <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (load) begin
                r_q       <= w_load_clean;
                r_preset  <= w_load_clean;
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (stop) begin
                            r_state <= ST_IDLE;
                        end else if (start && !w_q_zero) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end else if (tick && w_dec_ok) begin
                            r_q <= w_q_dec;
                            if (w_dec_zero) begin
                                r_state      <= ST_DONE;
                                r_running    <= 1'b0;
                                r_expired    <= 1'b1;
                                r_done_pulse <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (stop) begin
                            r_state <= ST_DONE;
                        end else if (start && !w_preset_zero) begin
                            r_q       <= r_preset;
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_expired <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_q          <= {QW{1'b0}};
                        r_running    <= 1'b0;
                        r_expired    <= 1'b0;
                        r_done_pulse <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q          = r_q;
    assign running    = r_running;
    assign expired    = r_expired;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (3 digits): directed scenarios
// followed by random control traffic, both checked against a decimal model.
module tb_bcd_countdown_timer;

    localparam int ND = 3;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_DONE = 2;

    logic            clk;
    logic            reset_n;
    logic            tick;
    logic            load;
    logic [4*ND-1:0] load_val;
    logic            start;
    logic            stop;
    logic [4*ND-1:0] q;
    logic            running;
    logic            expired;
    logic            done_pulse;

    int n_vec;
    int n_err;

    int m_val;
    int m_preset;
    int m_mode;
    int m_pulse;

    bcd_countdown_timer #(.NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .q          (q),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int sanitise(input logic [4*ND-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0;
        m_preset = 0;
        m_mode = MODE_IDLE;
        m_pulse = 0;
    endtask

    task automatic model_step(input logic ld, input logic [4*ND-1:0] lv,
                              input logic st, input logic sp, input logic tk);
        m_pulse = 0;
        if (ld) begin
            m_val = sanitise(lv);
            m_preset = m_val;
            m_mode = MODE_IDLE;
        end else if (m_mode == MODE_IDLE) begin
            if (!sp && st && m_val != 0) m_mode = MODE_RUN;
        end else if (m_mode == MODE_RUN) begin
            if (sp) begin
                m_mode = MODE_IDLE;
            end else if (tk && m_val > 0) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_mode = MODE_DONE;
                    m_pulse = 1;
                end
            end
        end else begin
            if (!sp && st && m_preset != 0) begin
                m_val = m_preset;
                m_mode = MODE_RUN;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"}, 32'(q), 32'(to_bcd(m_val)));
        chk({tag, "_running"}, 32'(running), 32'(m_mode == MODE_RUN));
        chk({tag, "_expired"}, 32'(expired), 32'(m_mode == MODE_DONE));
        chk({tag, "_done_pulse"}, 32'(done_pulse), 32'(m_pulse));
    endtask

    task automatic step(input logic ld, input logic [4*ND-1:0] lv, input logic st,
                        input logic sp, input logic tk, input string tag);
        load = ld;
        load_val = lv;
        start = st;
        stop = sp;
        tick = tk;
        @(posedge clk);
        model_step(ld, lv, st, sp, tk);
        #1;
        check_all(tag);
        load = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       r_ld;
        logic       r_st;
        logic       r_sp;
        logic       r_tk;

        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        tick = 1'b0;
        load = 1'b0;
        load_val = '0;
        start = 1'b0;
        stop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset while counting at 17
        step(1'b1, 12'h018, 1'b0, 1'b0, 1'b0, "rst_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "rst_start");
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "rst_tick");
        chk("rst_q17", 32'(q), 32'h017);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Full countdown from 12
        step(1'b1, 12'h012, 1'b0, 1'b0, 1'b0, "full_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "full_start");
        chk("full_start_q", 32'(q), 32'h012);
        for (int i = 0; i < 12; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "full_tick");
        chk("full_end_q", 32'(q), 32'h000);
        chk("full_end_pulse", 32'(done_pulse), 32'h1);
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "full_after");
        step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1, "full_after2");
        chk("full_expired", 32'(expired), 32'h1);
        chk("full_pulse_once", 32'(done_pulse), 32'h0);

        // Stop and tick together, then resume
        step(1'b1, 12'h025, 1'b0, 1'b0, 1'b0, "pause_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "pause_start");
        step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1, "pause_collide");
        chk("pause_q25", 32'(q), 32'h025);
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "pause_idle_tick");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "pause_resume");
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "pause_tick");
        chk("pause_q24", 32'(q), 32'h024);

        // Borrow across two digits and digit clamp
        step(1'b1, 12'h100, 1'b0, 1'b0, 1'b0, "borrow_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "borrow_start");
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "borrow_tick");
        chk("borrow_q099", 32'(q), 32'h099);
        step(1'b1, 12'h03C, 1'b0, 1'b0, 1'b0, "clamp_load");
        chk("clamp_q039", 32'(q), 32'h039);
        step(1'b1, 12'hFAB, 1'b0, 1'b0, 1'b0, "clamp_all");

        // Restart from DONE and zero preset
        step(1'b1, 12'h005, 1'b0, 1'b0, 1'b0, "restart_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "restart_start");
        for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, "restart_tick");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "restart_again");
        chk("restart_q05", 32'(q), 32'h005);
        chk("restart_running", 32'(running), 32'h1);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, "zero_load");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b1, "zero_start");
        chk("zero_not_running", 32'(running), 32'h0);

        // Load outranks everything
        step(1'b1, 12'h040, 1'b0, 1'b0, 1'b0, "prio_load0");
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "prio_start");
        step(1'b1, 12'h030, 1'b1, 1'b1, 1'b1, "prio_load");
        chk("prio_q30", 32'(q), 32'h030);

        // Random control traffic
        for (int i = 0; i < 600; i++) begin
            d0 = 4'($urandom_range(0, 15));
            d1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            d2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            r_ld = ($urandom_range(0, 24) == 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_sp = ($urandom_range(0, 14) == 0);
            r_tk = ($urandom_range(0, 1) == 0);
            step(r_ld, {d2, d1, d0}, r_st, r_sp, r_tk, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
